lz_normalizer: RTL

Multi-cycle leading-zero normalizer for a DATA_W-bit word. It counts leading zeros one nibble per cycle using the 4-bit leading-zero counter. It left-shifts the word so that its MSB is 1 and reports the shift amount. It sits directly downstream of the nibble counter, consuming its 4-bit count, and feeds mantissa-normalization and priority-encode consumers through a valid/ready handshake.

---
 rtl/lz_pkg.sv | 17 +
 rtl/lz_normalizer_count_zero.sv | 20 ++
 rtl/lz_normalizer.sv | 111 +++++++++++
 3 files changed

// File: rtl/lz_pkg.sv
// Shared types and constants for the multi-cycle leading-zero normalizer.
package lz_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int NIB_W = 4;

    // Shift-count width able to hold 0..data_w inclusive.
    function automatic int sh_w(input int data_w);
        return $clog2(data_w) + 1;
    endfunction

endpackage

// File: rtl/lz_normalizer_count_zero.sv
// 4-bit leading-zero counter; result ranges 0..4 (4 means an all-zero nibble).
module count_zero
    import lz_pkg::*;
(
    input  logic [NIB_W-1:0] i_nib,
    output logic [3:0]       o_cnt
);

    always_comb begin
        o_cnt = 4'd4;
        casez (i_nib)
            4'b1???: o_cnt = 4'd0;
            4'b01??: o_cnt = 4'd1;
            4'b001?: o_cnt = 4'd2;
            4'b0001: o_cnt = 4'd3;
            default: o_cnt = 4'd4;
        endcase
    end

endmodule

// File: rtl/lz_normalizer.sv
// Leading-zero normalizer: scans one nibble per cycle, left-justifies the word
// and reports the shift count through a valid/ready result handshake.
module lz_normalizer
    import lz_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int SH_W   = sh_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [SH_W-1:0]   o_shift,
    output logic              o_zero
);

    localparam int NIBS  = DATA_W / NIB_W;
    localparam int NIB_CW = $clog2(NIBS + 1);

    localparam logic [NIB_CW-1:0] NIB_LOAD = NIB_CW'(NIBS);
    localparam logic [NIB_CW-1:0] NIB_ONE  = NIB_CW'(1);
    localparam logic [SH_W-1:0]   CNT_NIB  = SH_W'(NIB_W);
    localparam logic [SH_W-1:0]   CNT_FULL = SH_W'(DATA_W);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   work_q,  work_d;
    logic [SH_W-1:0]     cnt_q,   cnt_d;
    logic [NIB_CW-1:0]   nib_q,   nib_d;
    logic                zero_q,  zero_d;

    logic [3:0]          z;
    logic [SH_W-1:0]     z_ext;

    count_zero u_count_zero (
        .i_nib (work_q[DATA_W-1 -: NIB_W]),
        .o_cnt (z)
    );

    assign z_ext = SH_W'(z);

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        nib_d   = nib_q;
        zero_d  = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    work_d  = i_data;
                    cnt_d   = '0;
                    nib_d   = NIB_LOAD;
                    zero_d  = 1'b0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (z == 4'd4) begin
                    if (nib_q > NIB_ONE) begin
                        work_d = work_q << NIB_W;
                        cnt_d  = cnt_q + CNT_NIB;
                        nib_d  = nib_q - NIB_ONE;
                    end else begin
                        // Last nibble also empty: the whole word was zero.
                        work_d  = '0;
                        cnt_d   = CNT_FULL;
                        zero_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    work_d  = work_q << z;
                    cnt_d   = cnt_q + z_ext;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            nib_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            nib_q   <= nib_d;
            zero_q  <= zero_d;
        end
    end

    assign o_ready = (state_q == ST_IDLE);
    assign o_valid = (state_q == ST_DONE);
    assign o_data  = work_q;
    assign o_shift = cnt_q;
    assign o_zero  = zero_q;

endmodule
